// File: rtl/data_memory_ws.sv
// Word-addressed data memory window for the MEM stage with a fixed, programmable
// number of wait cycles per access behind a request/ready handshake.
module data_memory_ws #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memoryRead,
  input  logic                  memoryWrite,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  busy,
  output logic                  error,
  output logic [1:0]            state_dbg
);

  // Handshake: the requester holds memoryRead/memoryWrite high until ready.
  // ready pulses for exactly one cycle; error is only meaningful alongside it.

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LIMIT    = (ADDR_WIDTH+1)'(BASE_ADDR) + (ADDR_WIDTH+1)'(DEPTH * BYTES);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [7:0]            CNT_INIT = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  state_t                state, next_state;
  logic [7:0]            cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  lat_wr, lat_fault, err_q;
  logic [IDX_W-1:0]      lat_idx;
  logic [DATA_WIDTH-1:0] lat_data;

  logic                  req;
  logic                  req_fault;
  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      req_idx;

  logic                  acc_wr, acc_fault;
  logic [IDX_W-1:0]      acc_idx;
  logic [DATA_WIDTH-1:0] acc_data;

  assign req       = memoryRead | memoryWrite;
  assign offset    = address - BASE;
  assign req_idx   = IDX_W'(offset >> OFS);
  assign req_fault = (address < BASE) | ({1'b0, address} >= LIMIT) |
                     ((address & OFS_MASK) != '0) | (memoryRead & memoryWrite);

  // With zero wait cycles the commit happens on the accepting edge, so the
  // live request is used instead of the not-yet-latched copy.
  assign acc_wr    = (state == S_IDLE) ? memoryWrite : lat_wr;
  assign acc_fault = (state == S_IDLE) ? req_fault   : lat_fault;
  assign acc_idx   = (state == S_IDLE) ? req_idx     : lat_idx;
  assign acc_data  = (state == S_IDLE) ? data_in     : lat_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (req) next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
      S_WAIT: if (cnt == 8'd0) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == S_DONE);
    error     = (state == S_DONE) & err_q;
    busy      = (state == S_WAIT) | ((state == S_IDLE) & req);
    state_dbg = state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= 8'd0;
      lat_wr    <= 1'b0;
      lat_fault <= 1'b0;
      lat_idx   <= '0;
      lat_data  <= '0;
      err_q     <= 1'b0;
      data      <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (state == S_IDLE && req) begin
        lat_wr    <= memoryWrite;
        lat_fault <= req_fault;
        lat_idx   <= req_idx;
        lat_data  <= data_in;
        cnt       <= CNT_INIT;
      end else if (state == S_WAIT && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (next_state == S_DONE && state != S_DONE) begin
        err_q <= acc_fault;
        if (!acc_fault) begin
          if (acc_wr) mem[acc_idx] <= acc_data;
          else        data         <= mem[acc_idx];
        end
      end
    end
  end

endmodule
